usb_setup_decoder: RTL
======================

# usb_setup_decoder

Consumes the bytes of a SETUP packet's DATA0 payload from the USB receive queue, stores the 8-byte request, and decodes it into a control-transfer response descriptor. Outputs are the byte count, configuration-ROM offset, source flag, stall flag and pending address. The block sits between the receive queue and the control-endpoint sequencer, which uses these outputs to run the data and status stages. It fetches descriptor lengths from the shared configuration ROM through a registered read port.

## Interface
- TIMEOUT, 16: idle cycles allowed with the FIFO empty before an incomplete packet is abandoned.
- ADDR_W, 8: configuration-ROM address width.
- clk  in  1  system clock (48 MHz USB clock).
- rst  in  1  asynchronous reset, active-low.
- usb_rst  in  1  bus reset from the USB core; synchronous clear, same effect as `rst`.
- start  in  1  one-cycle pulse: a SETUP transaction ended with valid CRC.
- fifo_empty  in  1  receive queue empty.
- fifo_data  in  8  receive queue read data, valid the cycle after `fifo_rd`.
- fifo_rd  out  1  receive queue read strobe.
- rom_addr  out  ADDR_W  configuration-ROM address.
- rom_data  in  8  ROM data, registered, valid one cycle after `rom_addr`.
- busy  out  1  high from the cycle after the accepted `start` until `done`.
- done  out  1  one-cycle pulse; all decode outputs are valid from this cycle.
- dir_in  out  1  bmRequestType[7].
- expected_bytes  out  8  data-stage length.
- config_offset  out  8  ROM start offset for the data stage.
- from_descriptor  out  1  1 = data comes from the ROM; 0 = data comes from the user path.
- stall  out  1  request is unsupported or malformed.
- addr_pending  out  7  new device address, captured on SET_ADDRESS; the sequencer applies it after the status stage.

## Operation
- Reset values: `fifo_rd`, `busy`, `done`, `dir_in`, `stall` and `from_descriptor` are 0. `expected_bytes`, `config_offset`, `rom_addr` and `addr_pending` are 0. State is IDLE.
- State machine: IDLE → CAPT → DECODE → LEN → DONE → IDLE.
- IDLE
  - On `start`, clear the byte counter and the timeout counter, then go to CAPT.
  - `start` is ignored in every other state.
- CAPT
  - Assert `fifo_rd` in each cycle where `!fifo_empty` and issued < 8.
  - Capture `fifo_data` into byte[n] on the cycle after each read.
  - After byte[7] is captured, go to DECODE.
  - The timeout counter counts cycles with `fifo_empty` and no read outstanding; it clears on every read.
  - When the counter reaches TIMEOUT, set `stall`=1, `expected_bytes`=0, and go to DONE.
  - Bytes beyond 8 are never read.
- DECODE: form the request fields, set `rom_addr`, then go to LEN.
  - bRequest = byte[1]; wValue = {byte[3], byte[2]}; wLength = {byte[7], byte[6]}.
- Request decode, by bRequest:
  - 0x00 GET_STATUS: offset 137, desc_len = 2, `from_descriptor`=1.
  - 0x05 SET_ADDRESS: `addr_pending` = byte[2][6:0], length 0, `from_descriptor`=1.
  - 0x06 GET_DESCRIPTOR, by byte[3]:
    - type 01: offset 0, desc_len = ROM[0].
    - type 02: offset 18, desc_len = ROM[20] (wTotalLength low byte).
    - type 03, by byte[2]:
      - 00 → 43.
      - AA → 47.
      - AB → 73.
      - AC → 47.
      - AD → 101.
      - desc_len = ROM[offset].
      - any other string index: `stall`.
    - any other type: `stall`.
  - 0x09 SET_CONFIGURATION: length 0, `from_descriptor`=1.
  - 0x30 (vendor OUT): length 0, `from_descriptor`=0.
  - 0x31 (vendor IN): offset 47, length = byte[6], `from_descriptor`=0.
  - Anything else: `stall`=1, length 0.
- Length clamp for ROM-sourced IN requests:
  - `expected_bytes` = desc_len if byte[7] != 0.
  - Otherwise `expected_bytes` = min(desc_len, byte[6]).
  - 8-bit unsigned comparison.
- `stall` forces `expected_bytes`=0.
- LEN: latch `rom_data` as desc_len; compute the outputs.
- DONE: pulse `done`; outputs hold until the next `start`.
- `rst` or `usb_rst` in any state aborts immediately to reset values, including `addr_pending`.
- An abort mid-CAPT leaves any unread bytes in the FIFO; the queue owner flushes them.

## Timing
- `start` in cycle 0 with 8 bytes already queued:
  - `fifo_rd` in cycles 1–8.
  - Captures in cycles 2–9.
  - DECODE in cycle 10.
  - LEN in cycle 11.
  - `done` in cycle 12.
- The ROM fetch is always performed, so latency is fixed at 12 cycles plus any FIFO stall cycles.
- `busy` is high for cycles 1–11 and low in the `done` cycle.
- `fifo_rd` is never asserted while `fifo_empty`=1.

## Structure
- Package `usb_ctrl_pkg` holds:
  - request codes (0x00, 0x05, 0x06, 0x09, 0x30, 0x31);
  - descriptor type codes;
  - ROM offsets 0, 18, 20, 43, 47, 73, 101, 137;
  - the string-index-to-offset function.
- The package is shared with the control-endpoint sequencer.
- No sub-module; a single FSM file.

## Test plan
- Get device descriptor: queue 80 06 00 01 00 00 40 00, ROM[0]=0x12 → `done` at cycle 12; offset 0, `expected_bytes`=0x12, `from_descriptor`=1, `stall`=0, `dir_in`=1.
- Get configuration descriptor: 80 06 00 02 00 00 09 00, ROM[20]=0x22 → offset 18, `expected_bytes`=9; repeat with wLength=0x00FF → `expected_bytes`=0x22.
- Set address: 00 05 2A 00 00 00 00 00 → `addr_pending`=0x2A, `expected_bytes`=0, `dir_in`=0.
- Unsupported string index: 80 06 07 03 ... → `stall`=1, `expected_bytes`=0. Unknown bRequest 0x0B → `stall`=1.
- Timeout and reset:
  - 5 bytes then FIFO starved → `done` with `stall`=1 after 16 empty cycles.
  - `usb_rst` asserted at byte 3 → all outputs return to 0 and the state returns to IDLE next cycle.
  - `rst` low asynchronously mid-LEN → outputs return to 0 immediately.
- Back-to-back: a second `start` while `busy` is ignored; a `start` right after `done` decodes a new 0x31 request with byte[6]=4 → `expected_bytes`=4, `from_descriptor`=0.

Source files
------------

// File: rtl/usb_ctrl_pkg.sv
// Control-endpoint constants shared by the SETUP decoder and the endpoint sequencer:
// request codes, descriptor types, configuration-ROM layout and the string-index lookup.
package usb_ctrl_pkg;

  localparam logic [7:0] REQ_GET_STATUS        = 8'h00;
  localparam logic [7:0] REQ_SET_ADDRESS       = 8'h05;
  localparam logic [7:0] REQ_GET_DESCRIPTOR    = 8'h06;
  localparam logic [7:0] REQ_SET_CONFIGURATION = 8'h09;
  localparam logic [7:0] REQ_VENDOR_OUT        = 8'h30;
  localparam logic [7:0] REQ_VENDOR_IN         = 8'h31;

  localparam logic [7:0] DESC_DEVICE = 8'h01;
  localparam logic [7:0] DESC_CONFIG = 8'h02;
  localparam logic [7:0] DESC_STRING = 8'h03;

  // Configuration-ROM map; OFF_CONFIG_TOTAL holds the low byte of wTotalLength.
  localparam logic [7:0] OFF_DEVICE       = 8'd0;
  localparam logic [7:0] OFF_CONFIG       = 8'd18;
  localparam logic [7:0] OFF_CONFIG_TOTAL = 8'd20;
  localparam logic [7:0] OFF_STR_LANG     = 8'd43;
  localparam logic [7:0] OFF_STR_VENDOR   = 8'd47;
  localparam logic [7:0] OFF_STR_PRODUCT  = 8'd73;
  localparam logic [7:0] OFF_STR_SERIAL   = 8'd101;
  localparam logic [7:0] OFF_STATUS       = 8'd137;

  localparam logic [7:0] STATUS_LEN = 8'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPT,
    ST_DECODE,
    ST_LEN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    LEN_ZERO,
    LEN_ROM,
    LEN_STATUS,
    LEN_WLENGTH
  } len_src_e;

  typedef struct packed {
    logic       hit;
    logic [7:0] offset;
  } str_lookup_t;

  function automatic str_lookup_t string_offset(input logic [7:0] idx);
    str_lookup_t r;
    r.hit = 1'b1;
    case (idx)
      8'h00:   r.offset = OFF_STR_LANG;
      8'hAA:   r.offset = OFF_STR_VENDOR;
      8'hAB:   r.offset = OFF_STR_PRODUCT;
      8'hAC:   r.offset = OFF_STR_VENDOR;
      8'hAD:   r.offset = OFF_STR_SERIAL;
      default: begin
        r.hit    = 1'b0;
        r.offset = 8'd0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/usb_setup_decoder_if.sv
// Receive-queue, ROM and decode-result signals of the SETUP decoder.
// master = the decoder itself, slave = the queue/ROM/sequencer side.
interface usb_setup_decoder_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              fifo_empty;
  logic [7:0]        fifo_data;
  logic              fifo_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              busy;
  logic              done;
  logic              dir_in;
  logic [7:0]        expected_bytes;
  logic [7:0]        config_offset;
  logic              from_descriptor;
  logic              stall;
  logic [6:0]        addr_pending;

  modport master (
    input  start, fifo_empty, fifo_data, rom_data,
    output fifo_rd, rom_addr, busy, done, dir_in, expected_bytes,
           config_offset, from_descriptor, stall, addr_pending
  );

  modport slave (
    output start, fifo_empty, fifo_data, rom_data,
    input  fifo_rd, rom_addr, busy, done, dir_in, expected_bytes,
           config_offset, from_descriptor, stall, addr_pending
  );
endinterface

// File: rtl/usb_setup_decoder.sv
// Captures the 8-byte SETUP payload, fetches the descriptor length from the configuration
// ROM and produces the data-stage descriptor for the control-endpoint sequencer.
module usb_setup_decoder
  import usb_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 8
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 usb_rst,
  usb_setup_decoder_if.master bus
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  state_e state, state_nxt;

  logic [3:0]        issued;
  logic [3:0]        captured;
  logic              rd_pending;
  logic [TCNT_W-1:0] idle_cnt;

  // Only the request fields the decode needs are kept; wIndex is skipped.
  logic       req_dir;
  logic [7:0] b_request;
  logic [7:0] w_value_lo;
  logic [7:0] w_value_hi;
  logic [7:0] w_length_lo;
  logic [7:0] w_length_hi;

  logic [7:0] rom_addr_q;
  logic       dir_in_q;
  logic [7:0] exp_bytes_q;
  logic [7:0] cfg_off_q;
  logic       from_desc_q;
  logic       stall_q;
  logic [6:0] addr_q;

  logic rd_now, capt_last, idle_cycle, timeout_hit;

  logic [7:0]  dec_offset;
  logic [7:0]  dec_fetch;
  logic        dec_src;
  logic        dec_stall;
  len_src_e    dec_len;
  str_lookup_t str;
  logic [7:0]  desc_len;
  logic [7:0]  exp_len;

  assign rd_now      = (state == ST_CAPT) && !bus.fifo_empty && (issued < 4'd8);
  assign capt_last   = (state == ST_CAPT) && rd_pending && (captured == 4'd7);
  assign idle_cycle  = (state == ST_CAPT) && bus.fifo_empty && !rd_pending;
  assign timeout_hit = idle_cycle && (idle_cnt == TCNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else if (usb_rst) state <= ST_IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.fifo_rd = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_CAPT;
      ST_CAPT: begin
        bus.fifo_rd = rd_now;
        bus.busy    = 1'b1;
        if (timeout_hit) state_nxt = ST_DONE;
        else if (capt_last) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        bus.busy  = 1'b1;
        state_nxt = ST_LEN;
      end
      ST_LEN: begin
        bus.busy  = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // dec_fetch is the ROM byte holding the length; it differs from the data-stage offset
  // only for the configuration descriptor.
  always_comb begin
    str        = string_offset(w_value_lo);
    dec_offset = 8'd0;
    dec_fetch  = 8'd0;
    dec_src    = 1'b0;
    dec_stall  = 1'b0;
    dec_len    = LEN_ZERO;
    case (b_request)
      REQ_GET_STATUS: begin
        dec_offset = OFF_STATUS;
        dec_fetch  = OFF_STATUS;
        dec_src    = 1'b1;
        dec_len    = LEN_STATUS;
      end
      REQ_SET_ADDRESS:       dec_src = 1'b1;
      REQ_SET_CONFIGURATION: dec_src = 1'b1;
      REQ_VENDOR_OUT:        dec_src = 1'b0;
      REQ_VENDOR_IN: begin
        dec_offset = OFF_STR_VENDOR;
        dec_fetch  = OFF_STR_VENDOR;
        dec_len    = LEN_WLENGTH;
      end
      REQ_GET_DESCRIPTOR: begin
        dec_src = 1'b1;
        case (w_value_hi)
          DESC_DEVICE: begin
            dec_offset = OFF_DEVICE;
            dec_fetch  = OFF_DEVICE;
            dec_len    = LEN_ROM;
          end
          DESC_CONFIG: begin
            dec_offset = OFF_CONFIG;
            dec_fetch  = OFF_CONFIG_TOTAL;
            dec_len    = LEN_ROM;
          end
          DESC_STRING: begin
            if (str.hit) begin
              dec_offset = str.offset;
              dec_fetch  = str.offset;
              dec_len    = LEN_ROM;
            end else begin
              dec_stall = 1'b1;
            end
          end
          default: dec_stall = 1'b1;
        endcase
      end
      default: dec_stall = 1'b1;
    endcase
  end

  always_comb begin
    desc_len = 8'd0;
    case (dec_len)
      LEN_ROM:     desc_len = bus.rom_data;
      LEN_STATUS:  desc_len = STATUS_LEN;
      LEN_WLENGTH: desc_len = w_length_lo;
      default:     desc_len = 8'd0;
    endcase
    exp_len = desc_len;
    if (dec_src && (w_length_hi == 8'd0) && (w_length_lo < desc_len)) exp_len = w_length_lo;
    if (dec_stall) exp_len = 8'd0;
  end

  // Capture counters, request bytes and the committed decode results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued      <= '0;
      captured    <= '0;
      rd_pending  <= 1'b0;
      idle_cnt    <= '0;
      req_dir     <= 1'b0;
      b_request   <= '0;
      w_value_lo  <= '0;
      w_value_hi  <= '0;
      w_length_lo <= '0;
      w_length_hi <= '0;
      rom_addr_q  <= '0;
      dir_in_q    <= 1'b0;
      exp_bytes_q <= '0;
      cfg_off_q   <= '0;
      from_desc_q <= 1'b0;
      stall_q     <= 1'b0;
      addr_q      <= '0;
    end else if (usb_rst) begin
      issued      <= '0;
      captured    <= '0;
      rd_pending  <= 1'b0;
      idle_cnt    <= '0;
      req_dir     <= 1'b0;
      b_request   <= '0;
      w_value_lo  <= '0;
      w_value_hi  <= '0;
      w_length_lo <= '0;
      w_length_hi <= '0;
      rom_addr_q  <= '0;
      dir_in_q    <= 1'b0;
      exp_bytes_q <= '0;
      cfg_off_q   <= '0;
      from_desc_q <= 1'b0;
      stall_q     <= 1'b0;
      addr_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            issued     <= '0;
            captured   <= '0;
            rd_pending <= 1'b0;
            idle_cnt   <= '0;
          end
        end
        ST_CAPT: begin
          rd_pending <= rd_now;
          if (rd_now) issued <= issued + 4'd1;
          if (rd_now) idle_cnt <= '0;
          else if (idle_cycle) idle_cnt <= idle_cnt + TCNT_W'(1);
          if (rd_pending) begin
            captured <= captured + 4'd1;
            case (captured[2:0])
              3'd0:    req_dir     <= bus.fifo_data[7];
              3'd1:    b_request   <= bus.fifo_data;
              3'd2:    w_value_lo  <= bus.fifo_data;
              3'd3:    w_value_hi  <= bus.fifo_data;
              3'd6:    w_length_lo <= bus.fifo_data;
              3'd7:    w_length_hi <= bus.fifo_data;
              default: ;
            endcase
          end
          if (timeout_hit) begin
            stall_q     <= 1'b1;
            exp_bytes_q <= 8'd0;
          end
        end
        ST_DECODE: rom_addr_q <= dec_fetch;
        ST_LEN: begin
          dir_in_q    <= req_dir;
          exp_bytes_q <= exp_len;
          cfg_off_q   <= dec_offset;
          from_desc_q <= dec_src;
          stall_q     <= dec_stall;
          if (b_request == REQ_SET_ADDRESS) addr_q <= w_value_lo[6:0];
        end
        default: ;
      endcase
    end
  end

  // The fetch address is driven during DECODE so the registered ROM answers in LEN.
  assign bus.rom_addr        = ADDR_W'((state == ST_DECODE) ? dec_fetch : rom_addr_q);
  assign bus.dir_in          = dir_in_q;
  assign bus.expected_bytes  = exp_bytes_q;
  assign bus.config_offset   = cfg_off_q;
  assign bus.from_descriptor = from_desc_q;
  assign bus.stall           = stall_q;
  assign bus.addr_pending    = addr_q;

endmodule
